// File: rtl/fetch_controller_if.sv
// Instruction-memory fetch bus: one request/response handshake.
// The fetch controller is the master (drives req/addr), memory is the slave.
interface fetch_controller_if;
  logic        req;
  logic [31:0] addr;
  logic        ready;
  logic [31:0] rdata;

  modport master (output req, addr, input ready, rdata);
  modport slave  (input req, addr, output ready, rdata);
endinterface

// File: rtl/fetch_controller.sv
// Fetch sequencer: picks the next PC each cycle, runs the imem handshake,
// drops responses made stale by a redirect and traps on a memory timeout.
module fetch_controller #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR = 32'h0000_0040,
  parameter int unsigned TIMEOUT     = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [31:0]               cur_pc,
  input  logic [31:0]               cur_pc_plus1,
  output logic [31:0]               next_pc,
  input  logic                      branch_taken,
  input  logic [31:0]               branch_target,
  input  logic                      jump_valid,
  input  logic [31:0]               jump_target,
  input  logic                      trap_req,
  input  logic                      stall,
  fetch_controller_if.master        imem,
  output logic [31:0]               instr_out,
  output logic [31:0]               instr_pc,
  output logic                      instr_valid,
  output logic                      fetch_fault
);

  typedef enum logic [1:0] {BOOT, REQ, HOLD, DRAIN} state_t;
  // Redirect strength; a larger encoding wins.
  typedef enum logic [1:0] {PRI_NONE, PRI_BRANCH, PRI_JUMP, PRI_TRAP} pri_t;

  localparam logic [15:0] TMO = 16'(TIMEOUT);

  state_t      state;
  logic [15:0] cnt;
  logic [31:0] pending;
  pri_t        pend_pri;

  logic        redirect;
  logic [31:0] redir_tgt;
  pri_t        redir_pri;
  logic        timeout;
  logic        take_new;
  logic [31:0] drain_tgt;

  // Resolve simultaneous redirects: trap > jump > branch.
  always_comb begin
    redirect  = trap_req | jump_valid | branch_taken;
    redir_tgt = branch_target;
    redir_pri = PRI_NONE;
    if (trap_req) begin
      redir_tgt = TRAP_VECTOR;
      redir_pri = PRI_TRAP;
    end else if (jump_valid) begin
      redir_tgt = jump_target;
      redir_pri = PRI_JUMP;
    end else if (branch_taken) begin
      redir_tgt = branch_target;
      redir_pri = PRI_BRANCH;
    end
  end

  assign timeout   = ((state == REQ) || (state == DRAIN)) && (cnt >= TMO);
  // While draining, a newer redirect replaces the queued one unless the
  // queued one is stronger (e.g. a trap is not undone by a later branch).
  assign take_new  = redirect && (redir_pri >= pend_pri);
  assign drain_tgt = take_new ? redir_tgt : pending;
  assign imem.addr = cur_pc;

  // Next-PC select and request strobe, combinational from state and inputs.
  always_comb begin
    next_pc  = cur_pc;
    imem.req = 1'b0;
    if (rst) begin
      next_pc = RESET_PC;
    end else if (timeout) begin
      next_pc = TRAP_VECTOR;
    end else begin
      case (state)
        BOOT: next_pc = RESET_PC;
        REQ: begin
          imem.req = 1'b1;
          if (imem.ready) begin
            if (redirect)    next_pc = redir_tgt;
            else if (!stall) next_pc = cur_pc_plus1;
          end
        end
        HOLD: begin
          if (redirect)    next_pc = redir_tgt;
          else if (!stall) next_pc = cur_pc_plus1;
        end
        DRAIN: begin
          imem.req = 1'b1;
          if (imem.ready) next_pc = drain_tgt;
        end
        default: next_pc = cur_pc;
      endcase
    end
  end

  // State, wait counter, pending redirect and registered decode outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= BOOT;
      cnt         <= '0;
      pending     <= '0;
      pend_pri    <= PRI_NONE;
      instr_out   <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      fetch_fault <= 1'b0;
    end else begin
      fetch_fault <= 1'b0;
      if (timeout) begin
        // Abandon the request and restart fetching at the trap vector.
        fetch_fault <= 1'b1;
        instr_valid <= 1'b0;
        cnt         <= '0;
        pend_pri    <= PRI_NONE;
        state       <= REQ;
      end else begin
        case (state)
          BOOT: begin
            instr_valid <= 1'b0;
            cnt         <= '0;
            state       <= REQ;
          end
          REQ: begin
            if (imem.ready) begin
              cnt <= '0;
              if (redirect) begin
                instr_valid <= 1'b0;
              end else begin
                instr_out   <= imem.rdata;
                instr_pc    <= cur_pc;
                instr_valid <= 1'b1;
                if (stall) state <= HOLD;
              end
            end else begin
              instr_valid <= 1'b0;
              if (redirect) begin
                // Response still owed for cur_pc; wait it out, then redirect.
                pending  <= redir_tgt;
                pend_pri <= redir_pri;
                cnt      <= '0;
                state    <= DRAIN;
              end else if (cnt != 16'hFFFF) begin
                cnt <= cnt + 16'd1;
              end
            end
          end
          HOLD: begin
            cnt <= '0;
            if (redirect || !stall) begin
              instr_valid <= 1'b0;
              state       <= REQ;
            end
          end
          DRAIN: begin
            instr_valid <= 1'b0;
            if (imem.ready) begin
              cnt      <= '0;
              pend_pri <= PRI_NONE;
              state    <= REQ;
            end else begin
              if (take_new) begin
                pending  <= redir_tgt;
                pend_pri <= redir_pri;
              end
              if (cnt != 16'hFFFF) cnt <= cnt + 16'd1;
            end
          end
          default: state <= BOOT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller: a PC register closes the loop on
// next_pc; every cycle is a vector of inputs plus hand-computed outputs.
module tb_fetch_controller;
  localparam logic [31:0] RST_PC = 32'h0000_0010;
  localparam logic [31:0] TRAP   = 32'h0000_0040;
  localparam int          TMO    = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc  = 32'h0;
  logic [31:0] cur_pc_plus1;
  logic [31:0] next_pc;
  logic        branch_taken = 1'b0, jump_valid = 1'b0, trap_req = 1'b0, stall = 1'b0;
  logic [31:0] branch_target = 32'h0, jump_target = 32'h0;
  logic [31:0] instr_out, instr_pc;
  logic        instr_valid, fetch_fault;

  fetch_controller_if imem();

  fetch_controller #(.RESET_PC(RST_PC), .TRAP_VECTOR(TRAP), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .cur_pc(pc), .cur_pc_plus1(cur_pc_plus1), .next_pc(next_pc),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump_valid(jump_valid), .jump_target(jump_target), .trap_req(trap_req),
    .stall(stall), .imem(imem), .instr_out(instr_out), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;
  // PC register: loads next_pc every cycle.
  always @(posedge clk) pc <= next_pc;
  assign cur_pc_plus1 = pc + 32'd1;

  typedef struct {
    logic rs, br, jp, tr, st, rdy;
    logic [31:0] bt, jt, rd;
    logic [31:0] npc; logic req; logic [31:0] addr;
    logic vld; logic [31:0] ipc, iout; logic flt;
  } vec_t;

  int checks = 0;
  int failures = 0;

  function automatic vec_t v(logic rs, logic br, logic [31:0] bt, logic jp, logic [31:0] jt,
                             logic tr, logic st, logic rdy, logic [31:0] rd,
                             logic [31:0] npc, logic req, logic [31:0] addr,
                             logic vld, logic [31:0] ipc, logic [31:0] iout, logic flt);
    vec_t t;
    t.rs = rs; t.br = br; t.bt = bt; t.jp = jp; t.jt = jt; t.tr = tr; t.st = st;
    t.rdy = rdy; t.rd = rd; t.npc = npc; t.req = req; t.addr = addr;
    t.vld = vld; t.ipc = ipc; t.iout = iout; t.flt = flt;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs after the falling edge, then compare all outputs.
  task automatic step(input vec_t t, input string tag);
    @(negedge clk);
    rst = t.rs; branch_taken = t.br; branch_target = t.bt;
    jump_valid = t.jp; jump_target = t.jt; trap_req = t.tr; stall = t.st;
    imem.ready = t.rdy; imem.rdata = t.rd;
    #1;
    chk({tag, " next_pc"},     next_pc,            t.npc);
    chk({tag, " imem_req"},    32'(imem.req),      32'(t.req));
    chk({tag, " imem_addr"},   imem.addr,          t.addr);
    chk({tag, " instr_valid"}, 32'(instr_valid),   32'(t.vld));
    chk({tag, " instr_pc"},    instr_pc,           t.ipc);
    chk({tag, " instr_out"},   instr_out,          t.iout);
    chk({tag, " fetch_fault"}, 32'(fetch_fault),   32'(t.flt));
  endtask

  vec_t tbl[$];

  initial begin
    imem.ready = 1'b0;
    imem.rdata = 32'h0;

    //          rs br bt       jp jt           tr st rdy rdata         npc         req addr         vld ipc          iout       flt
    // reset, boot, zero-wait stream 0x10,0x11,0x12
    tbl.push_back(v(1,0,0,       0,0,           0,0,0, 0,            32'h10,      0,32'h10,       0,0,           0,         0));
    tbl.push_back(v(0,0,0,       0,0,           0,0,0, 0,            32'h10,      0,32'h10,       0,0,           0,         0));
    tbl.push_back(v(0,0,0,       0,0,           0,0,1, 32'hA10,      32'h11,      1,32'h10,       0,0,           0,         0));
    tbl.push_back(v(0,0,0,       0,0,           0,0,1, 32'hA11,      32'h12,      1,32'h11,       1,32'h10,      32'hA10,   0));
    tbl.push_back(v(0,0,0,       0,0,           0,0,1, 32'hA12,      32'h13,      1,32'h12,       1,32'h11,      32'hA11,   0));
    tbl.push_back(v(0,0,0,       0,0,           0,0,0, 0,            32'h13,      1,32'h13,       1,32'h12,      32'hA12,   0));
    tbl.push_back(v(0,0,0,       0,0,           0,0,0, 0,            32'h13,      1,32'h13,       0,32'h12,      32'hA12,   0));
    // ready + jump: response discarded, redirect to 0x20
    tbl.push_back(v(0,0,0,       1,32'h20,      0,0,1, 32'hDEAD,     32'h20,      1,32'h13,       0,32'h12,      32'hA12,   0));
    // stall for 3 cycles at 0x20, then resume at 0x21
    tbl.push_back(v(0,0,0,       0,0,           0,1,1, 32'hA20,      32'h20,      1,32'h20,       0,32'h12,      32'hA12,   0));
    tbl.push_back(v(0,0,0,       0,0,           0,1,0, 0,            32'h20,      0,32'h20,       1,32'h20,      32'hA20,   0));
    tbl.push_back(v(0,0,0,       0,0,           0,1,0, 0,            32'h20,      0,32'h20,       1,32'h20,      32'hA20,   0));
    tbl.push_back(v(0,0,0,       0,0,           0,0,0, 0,            32'h21,      0,32'h20,       1,32'h20,      32'hA20,   0));
    tbl.push_back(v(0,0,0,       1,32'h05,      0,0,1, 32'hBAD1,     32'h05,      1,32'h21,       0,32'h20,      32'hA20,   0));
    // 3-wait memory at 0x05, branch to 0x80 mid-wait -> drain, discard
    tbl.push_back(v(0,0,0,       0,0,           0,0,0, 0,            32'h05,      1,32'h05,       0,32'h20,      32'hA20,   0));
    tbl.push_back(v(0,1,32'h80,  0,0,           0,0,0, 0,            32'h05,      1,32'h05,       0,32'h20,      32'hA20,   0));
    tbl.push_back(v(0,0,0,       0,0,           0,0,0, 0,            32'h05,      1,32'h05,       0,32'h20,      32'hA20,   0));
    tbl.push_back(v(0,0,0,       0,0,           0,0,1, 32'hBAD5,     32'h80,      1,32'h05,       0,32'h20,      32'hA20,   0));
    tbl.push_back(v(0,0,0,       0,0,           0,0,1, 32'hA80,      32'h81,      1,32'h80,       0,32'h20,      32'hA20,   0));
    // trap + jump + branch together -> trap vector
    tbl.push_back(v(0,1,32'h300, 1,32'h200,     1,0,1, 32'hBAD2,     32'h40,      1,32'h81,       1,32'h80,      32'hA80,   0));
    // drain priority: queued jump replaced by trap, later branch ignored
    tbl.push_back(v(0,1,32'h300, 1,32'h200,     0,0,0, 0,            32'h40,      1,32'h40,       0,32'h80,      32'hA80,   0));
    tbl.push_back(v(0,0,0,       0,0,           1,0,0, 0,            32'h40,      1,32'h40,       0,32'h80,      32'hA80,   0));
    tbl.push_back(v(0,1,32'h300, 0,0,           0,0,0, 0,            32'h40,      1,32'h40,       0,32'h80,      32'hA80,   0));
    tbl.push_back(v(0,0,0,       0,0,           0,0,1, 32'hBAD3,     32'h40,      1,32'h40,       0,32'h80,      32'hA80,   0));
    tbl.push_back(v(0,0,0,       0,0,           0,0,1, 32'hA40,      32'h41,      1,32'h40,       0,32'h80,      32'hA80,   0));
    // drain with ready + new jump in the same cycle uses the new target
    tbl.push_back(v(0,1,32'h100, 0,0,           0,0,0, 0,            32'h41,      1,32'h41,       1,32'h40,      32'hA40,   0));
    tbl.push_back(v(0,0,0,       1,32'hFFFFFFFF,0,0,1, 32'hBAD4,     32'hFFFFFFFF,1,32'h41,       0,32'h40,      32'hA40,   0));
    // PC wrap
    tbl.push_back(v(0,0,0,       0,0,           0,0,1, 32'hAFF,      32'h0,       1,32'hFFFFFFFF, 0,32'h40,      32'hA40,   0));
    tbl.push_back(v(0,0,0,       0,0,           0,0,1, 32'hA00,      32'h1,       1,32'h0,        1,32'hFFFFFFFF,32'hAFF,   0));
    tbl.push_back(v(0,0,0,       0,0,           0,0,0, 0,            32'h1,       1,32'h1,        1,32'h0,       32'hA00,   0));
    // branch while held in HOLD
    tbl.push_back(v(0,0,0,       0,0,           0,1,1, 32'hA01,      32'h1,       1,32'h1,        0,32'h0,       32'hA00,   0));
    tbl.push_back(v(0,1,32'h10,  0,0,           0,1,0, 0,            32'h10,      0,32'h1,        1,32'h1,       32'hA01,   0));
    tbl.push_back(v(0,0,0,       0,0,           0,0,0, 0,            32'h10,      1,32'h10,       0,32'h1,       32'hA01,   0));

    repeat (2) @(posedge clk);
    foreach (tbl[i]) step(tbl[i], $sformatf("vec%0d", i));

    // Timeout: fresh request at 0x50 never answered.
    step(v(0,0,0, 1,32'h50, 0,0,1, 0, 32'h50,1,32'h10, 0,32'h1,32'hA01,0), "tmo_start");
    for (int k = 0; k < TMO; k++)
      step(v(0,0,0, 0,0, 0,0,0, 0, 32'h50,1,32'h50, 0,32'h1,32'hA01,0), $sformatf("tmo_wait%0d", k));
    step(v(0,0,0, 0,0, 0,0,0, 0, TRAP,0,32'h50, 0,32'h1,32'hA01,0), "tmo_hit");
    step(v(0,0,0, 0,0, 0,0,0, 0, TRAP,1,TRAP,   0,32'h1,32'hA01,1), "tmo_fault");
    // Single pulse; branch enters DRAIN, then reset mid-drain.
    step(v(0,1,32'h90, 0,0, 0,0,0, 0, TRAP,1,TRAP, 0,32'h1,32'hA01,0), "drain_enter");
    step(v(1,0,0, 0,0, 0,0,0, 0, RST_PC,0,TRAP, 0,32'h1,32'hA01,0), "rst_mid");
    // Stale response arriving in BOOT must not be delivered.
    step(v(0,0,0, 0,0, 0,0,1, 32'hBAD, RST_PC,0,RST_PC, 0,0,0,0), "rst_boot");
    step(v(0,0,0, 0,0, 0,0,1, 32'h111, 32'h11,1,RST_PC, 0,0,0,0), "rst_req");
    step(v(0,0,0, 0,0, 0,0,0, 0, 32'h11,1,32'h11, 1,32'h10,32'h111,0), "rst_deliver");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fetch_controller.md
# fetch_controller

Sequencer that drives the program counter's next-value input and the instruction-memory fetch handshake. Each cycle it selects the next PC from sequential (PC+1), branch, jump or trap sources. It holds the PC while memory is busy or decode stalls, discards stale responses after a redirect, and raises a fault on memory timeout. It sits between the PC register, instruction memory and the decode stage; PC values are word addresses.

## Interface
- RESET_PC, 32'h0000_0000, word address fetched first after reset
- TRAP_VECTOR, 32'h0000_0040, redirect target for trap_req and timeout
- TIMEOUT, 16, max cycles waiting on imem_ready before fault (>=2)

- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- cur_pc  in  32  current PC register value
- cur_pc_plus1  in  32  current PC + 1
- next_pc  out  32  value loaded into PC on next edge (PC loads every cycle)
- branch_taken  in  1  redirect to branch_target
- branch_target  in  32
- jump_valid  in  1  redirect to jump_target
- jump_target  in  32
- trap_req  in  1  redirect to TRAP_VECTOR
- stall  in  1  decode cannot accept instruction this cycle
- imem_req  out  1  fetch request, address = imem_addr
- imem_addr  out  32  equals cur_pc
- imem_ready  in  1  imem_rdata valid this cycle, completes request
- imem_rdata  in  32
- instr_out  out  32  fetched instruction (registered)
- instr_pc  out  32  PC of instr_out
- instr_valid  out  1  instr_out valid to decode
- fetch_fault  out  1  one-cycle pulse on timeout

## Operation
- States: BOOT, REQ, HOLD, DRAIN.
- Redirect priority: trap_req > jump_valid > branch_taken. A redirect is any of the three asserted in a cycle. Target is TRAP_VECTOR / jump_target / branch_target.
- BOOT: next_pc = RESET_PC, imem_req=0; next state REQ.
- REQ: imem_req=1, imem_addr=cur_pc. The wait counter increments each cycle without imem_ready.
  - ready, no redirect, no stall: latch instr_out=imem_rdata, instr_pc=cur_pc, instr_valid=1; next_pc=cur_pc_plus1; stay REQ.
  - ready, no redirect, stall: latch as above; next_pc=cur_pc; go HOLD.
  - ready with redirect: discard rdata, instr_valid=0, next_pc=target, stay REQ.
  - no ready, redirect: latch target into pending register, next_pc=cur_pc, go DRAIN.
  - no ready, no redirect: next_pc=cur_pc.
- HOLD: imem_req=0, instr_out/instr_pc held, instr_valid=1, next_pc=cur_pc.
  - stall drops: go REQ with next_pc=cur_pc_plus1, instr_valid=0 next cycle unless new data arrives.
  - redirect in HOLD: instr_valid=0, next_pc=target, go REQ.
- DRAIN: imem_req=1 (outstanding request kept), next_pc=cur_pc. On imem_ready: discard rdata, next_pc=pending target, go REQ. A later higher-priority redirect in DRAIN overwrites the pending target; same-cycle ready plus redirect uses the new target.
- Timeout: counter reaches TIMEOUT in REQ or DRAIN → fetch_fault=1 for one cycle, imem_req=0 that cycle, instr_valid=0, next_pc=TRAP_VECTOR, counter cleared, go REQ.
- Counter clears on every imem_ready and every state change; 16-bit saturating.
- instr_valid in REQ is a one-cycle pulse per accepted response; decode must consume it the same cycle unless stall is asserted.

## Timing
- rst sampled at posedge. While rst=1: next_pc=RESET_PC, imem_req=0, instr_valid=0, instr_out=0, instr_pc=0, fetch_fault=0, counter=0, pending=0. Next state is BOOT.
- Reset mid-request abandons the outstanding request; no response is delivered.
- next_pc, imem_req and imem_addr are combinational from state and inputs. instr_out, instr_pc, instr_valid and fetch_fault are registered and visible the cycle after the enabling edge.
- Zero-wait memory (ready in request cycle) gives 1 instruction/cycle. Latency from request to instr_valid is 1 cycle after ready.
- Redirect-to-first-request of target: 1 cycle (REQ/HOLD) or 1 cycle after drain completes.
- PC arithmetic wraps mod 2^32 (32'hFFFF_FFFF + 1 = 0), supplied by cur_pc_plus1.

## Test plan
- Reset then zero-wait memory: rst 2 cycles, RESET_PC=0x10 → imem_addr 0x10,0x11,0x12 on consecutive cycles; instr_valid high continuously from the cycle after the first ready.
- Stall during delivery: stall=1 for 3 cycles at PC 0x20 → instr_pc stays 0x20 with instr_valid=1 and imem_req=0. After stall drops, next fetch is 0x21.
- Redirect with 3-wait memory: branch_taken to 0x80 while waiting at 0x05 → DRAIN, response for 0x05 discarded (no instr_valid), next imem_addr=0x80.
- Priority: trap_req, jump_valid (0x200) and branch_taken (0x300) in the same cycle → next_pc=TRAP_VECTOR 0x40.
- Timeout: imem_ready held low, TIMEOUT=16 → fetch_fault pulses once, 16 cycles after request start; next imem_addr=0x40.
- Wrap and reset mid-op: cur_pc=0xFFFF_FFFF fetch → next_pc=0. Asserting rst during DRAIN → all outputs return to reset values next cycle; fetch restarts at RESET_PC.
